sd_rx_fifo: RTL and testbench
=============================

Name: sd_rx_fifo

Overview:
- Receive-direction data buffer for the SD controller, single clock domain.
- The SD DAT receiver delivers 4-bit nibbles, MSB-first. This block packs them into 32-bit words and stores the words in a circular RAM.
- The host/DMA side pops words with a show-ahead read port.
- Counterpart of the TX FIFO: written from the card side, read from the bus side, with occupancy and overrun reporting for the DMA/interrupt logic.

Parameters:
- DEPTH, 8, number of 32-bit words; must be a power of two.
- ADR_SIZE, 4, pointer width = log2(DEPTH)+1; the MSB is the wrap bit.

Ports:
- clk  in  1  single clock (SD data clock domain).
- rst  in  1  reset, synchronous, active-high.
- dat_i  in  4  received nibble; bit 3 is the most significant.
- dat_valid_i  in  1  dat_i is valid this cycle.
- dat_last_i  in  1  final nibble of the data block; qualified by dat_valid_i.
- rd  in  1  pop request from host/DMA.
- q  out  32  word at the head of the FIFO (show-ahead).
- empty  out  1  FIFO holds no words.
- full  out  1  FIFO holds DEPTH words.
- mem_fill  out  ADR_SIZE  number of stored words, 0..DEPTH.
- overrun  out  1  sticky: a packed word was dropped.
- clr_ovr  in  1  clears overrun.

Behaviour:
- Reset is synchronous, active-high, one clock; evaluated before all other actions. Reset state:
  - wr_ptr, rd_ptr = 0
  - nibble count nib_cnt = 0; packing register = 0
  - overrun = 0
  - resulting outputs: empty=1, full=0, mem_fill=0
  - q is undefined while empty
  - reset mid-word discards the partial word.
- Packer: nib_cnt is 3 bits, with states COLLECT (nib_cnt 0..6) and COMMIT (8th nibble, or dat_last_i).
  - Nibble k of a word (k=0..7) occupies bits [31-4k : 28-4k].
  - On dat_valid_i with nib_cnt<7 and !dat_last_i: shift the nibble in, nib_cnt+1.
- Commit: on dat_valid_i && (nib_cnt==7 || dat_last_i).
  - Commit word = packing register with dat_i in slot nib_cnt; unfilled lower slots are zero.
  - The word is written to ram[wr_ptr[ADR_SIZE-2:0]] at that edge and wr_ptr increments.
  - nib_cnt and the packing register return to 0 at the same edge.
  - dat_valid_i low: no change; nibbles may arrive with gaps.
- Write acceptance: wr_ok = commit && (!full || (rd && !empty)).
  - A simultaneous pop frees a slot, so a commit while full is accepted when rd is asserted.
  - A commit with !wr_ok drops the word, sets overrun, and leaves wr_ptr unchanged. The packer still clears.
- Read: on rd && !empty, rd_ptr increments. rd while empty is ignored: no pointer change, no error.
- q = ram[rd_ptr[ADR_SIZE-2:0]], combinational.
- Latency: a committed word appears on q, with empty=0, from the cycle after the commit edge.
- Pointers are plain binary and wrap naturally (DEPTH is a power of two); the MSB toggles each lap.
  - empty = (wr_ptr == rd_ptr)
  - full = low bits equal && MSBs differ
  - mem_fill = wr_ptr - rd_ptr, modulo 2^ADR_SIZE; reaches DEPTH when full.
- Simultaneous write and read: mem_fill is unchanged; the pointers advance independently.
- overrun: set on a dropped commit; cleared by clr_ovr. Set has priority when both occur in the same cycle.
- No combinational path from dat_i to q.

Decomposition:
- SD_defines.v gains FIFO_RX_MEM_DEPTH and FIFO_RX_MEM_ADR_SIZE. These are the parameter defaults and are used by the instantiating data-path top.
- One natural sub-module, sd_nibble_packer: owns nib_cnt, the packing register, and the commit/last logic; outputs word[31:0] and commit.
- The FIFO core stays in sd_rx_fifo.

Test Plan:
- Reset, then 8 valid nibbles 1,2,...,8 -> empty deasserts the cycle after the 8th nibble; q=32'h12345678; mem_fill=1.
- 3 nibbles A,B,C with dat_last_i on C -> q=32'hABC00000; the next nibble starts a fresh word at bits [31:28].
- Fill 8 words with no reads -> full=1, mem_fill=8. Commit a 9th word with rd=0 -> overrun=1, contents unchanged. Pulse clr_ovr -> overrun=0.
- While full, commit a word with rd=1 in the same cycle -> head popped, new word stored, full stays 1, overrun stays 0.
- Stream 20 words with interleaved pops, crossing the pointer wrap twice -> read-back order and values match, empty/full never falsely asserted.
- Assert rst after 5 nibbles with 2 words stored -> next cycle empty=1, mem_fill=0, overrun=0. The next 8 nibbles form one clean word.

Source files
------------

// File: rtl/sd_rx_fifo_pkg.sv
// rtl/sd_rx_fifo_pkg.sv - shared constants, types and helpers for the SD receive FIFO
//
// Purpose : parameter defaults for the RX FIFO, packer phase type and a
//           nibble-placement helper used by the packer.
// Contents: FIFO_RX_MEM_DEPTH    - default word depth (power of two)
//           FIFO_RX_MEM_ADR_SIZE - default pointer width, log2(depth)+1
//           pk_phase_e           - packer phase: collecting or committing
//           put_nibble()         - write a nibble into word slot 0..7
package sd_rx_fifo_pkg;

    localparam int FIFO_RX_MEM_DEPTH    = 8;
    localparam int FIFO_RX_MEM_ADR_SIZE = 4;

    typedef enum logic {
        PK_COLLECT = 1'b0,
        PK_COMMIT  = 1'b1
    } pk_phase_e;

    // Slot k holds bits [31-4k : 28-4k]; the low index 28-4k equals 4*(~k)
    // for a 3-bit k, so the inverted slot number selects the nibble lane.
    function automatic logic [31:0] put_nibble(input logic [31:0] word,
                                               input logic [2:0]  slot,
                                               input logic [3:0]  nib);
        logic [31:0] r;
        r = word;
        r[{~slot, 2'b00} +: 4] = nib;
        return r;
    endfunction

endpackage

// File: rtl/sd_nibble_packer.sv
// rtl/sd_nibble_packer.sv - packs MSB-first SD nibbles into 32-bit words
//
// Purpose : collects up to eight nibbles into a word; commits on the eighth
//           nibble or on the block's last nibble, zero-filling unused slots.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           dat_i          - received nibble (bit 3 most significant)
//           dat_valid_i    - dat_i valid this cycle
//           dat_last_i     - final nibble of the data block
//           word_o         - word to be written when commit_o is high
//           commit_o       - a complete (or terminated) word is ready this cycle
module sd_nibble_packer
    import sd_rx_fifo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  dat_i,
    input  logic        dat_valid_i,
    input  logic        dat_last_i,
    output logic [31:0] word_o,
    output logic        commit_o
);

    logic [2:0]  nib_cnt_q, nib_cnt_d;
    logic [31:0] pack_q,    pack_d;
    pk_phase_e   phase;

    always_comb begin
        phase    = (dat_last_i || (nib_cnt_q == 3'd7)) ? PK_COMMIT : PK_COLLECT;
        // Current nibble merged into the partial word; lower slots are still zero.
        word_o   = put_nibble(pack_q, nib_cnt_q, dat_i);
        commit_o = dat_valid_i && (phase == PK_COMMIT);

        nib_cnt_d = nib_cnt_q;
        pack_d    = pack_q;
        if (dat_valid_i) begin
            if (phase == PK_COMMIT) begin
                // The packer restarts whether or not the FIFO accepts the word.
                nib_cnt_d = 3'd0;
                pack_d    = 32'd0;
            end else begin
                nib_cnt_d = nib_cnt_q + 3'd1;
                pack_d    = word_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_cnt_q <= 3'd0;
            pack_q    <= 32'd0;
        end else begin
            nib_cnt_q <= nib_cnt_d;
            pack_q    <= pack_d;
        end
    end

endmodule

// File: rtl/sd_rx_fifo.sv
// rtl/sd_rx_fifo.sv - SD receive FIFO: nibble packer plus circular word RAM
//
// Purpose : stores packed 32-bit words from the SD DAT receiver and presents
//           them on a show-ahead read port for the host/DMA side.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           dat_i          - received nibble, MSB-first
//           dat_valid_i    - dat_i valid this cycle
//           dat_last_i     - final nibble of the block
//           rd             - pop request
//           q              - word at the head of the FIFO (undefined while empty)
//           empty, full    - occupancy flags
//           mem_fill       - stored word count, 0..DEPTH
//           overrun        - sticky, a committed word was dropped
//           clr_ovr        - clears overrun (a same-cycle drop wins)
module sd_rx_fifo
    import sd_rx_fifo_pkg::*;
#(
    parameter int DEPTH    = FIFO_RX_MEM_DEPTH,
    parameter int ADR_SIZE = FIFO_RX_MEM_ADR_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          dat_i,
    input  logic                dat_valid_i,
    input  logic                dat_last_i,
    input  logic                rd,
    output logic [31:0]         q,
    output logic                empty,
    output logic                full,
    output logic [ADR_SIZE-1:0] mem_fill,
    output logic                overrun,
    input  logic                clr_ovr
);

    localparam int AW = ADR_SIZE - 1;

    logic [31:0]         word;
    logic                commit;
    logic [ADR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic                overrun_q, overrun_d;
    logic                rd_ok, wr_ok;
    logic [31:0]         ram_q [DEPTH];

    sd_nibble_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .dat_i       (dat_i),
        .dat_valid_i (dat_valid_i),
        .dat_last_i  (dat_last_i),
        .word_o      (word),
        .commit_o    (commit)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign mem_fill = wr_ptr_q - rd_ptr_q;
    assign q        = ram_q[rd_ptr_q[AW-1:0]];
    assign overrun  = overrun_q;

    always_comb begin
        rd_ok = rd && !empty;
        // A same-cycle pop frees the slot being written while full.
        wr_ok = commit && (!full || rd_ok);

        rd_ptr_d  = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d  = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;

        overrun_d = overrun_q;
        if (commit && !wr_ok) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is not reset; contents are only visible once a word is committed.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            ram_q[wr_ptr_q[AW-1:0]] <= word;
        end
    end

endmodule

// File: tb/tb_sd_rx_fifo.sv
// tb/tb_sd_rx_fifo.sv - self-checking bench for sd_rx_fifo
module tb_sd_rx_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  dat_i = '0;
    logic        dat_valid_i = 1'b0;
    logic        dat_last_i = 1'b0;
    logic        rd = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [31:0] q;
    logic        empty;
    logic        full;
    logic [3:0]  mem_fill;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a queue of stored words plus the partial word in progress.
    logic [31:0] mq[$];
    int          m_cnt = 0;
    logic [31:0] m_word = '0;
    logic        m_ovr = 1'b0;

    sd_rx_fifo #(.DEPTH(8), .ADR_SIZE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .dat_i       (dat_i),
        .dat_valid_i (dat_valid_i),
        .dat_last_i  (dat_last_i),
        .rd          (rd),
        .q           (q),
        .empty       (empty),
        .full        (full),
        .mem_fill    (mem_fill),
        .overrun     (overrun),
        .clr_ovr     (clr_ovr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_head();
        return (mq.size() > 0) ? mq[0] : 32'd0;
    endfunction

    // Drive one cycle of inputs, advance the model, and return 1 ns after the edge.
    task automatic tick(input logic [3:0] d, input logic v, input logic l,
                        input logic r, input logic c);
        logic        pop;
        logic        drop;
        logic [31:0] w;
        dat_i = d; dat_valid_i = v; dat_last_i = l; rd = r; clr_ovr = c;
        if (rst) begin
            mq.delete();
            m_cnt  = 0;
            m_word = '0;
            m_ovr  = 1'b0;
        end else begin
            pop  = r && (mq.size() > 0);
            drop = 1'b0;
            w    = m_word | (32'(d) << (28 - 4 * m_cnt));
            if (pop) void'(mq.pop_front());
            if (v) begin
                if (m_cnt == 7 || l) begin
                    if (mq.size() < DEPTH) mq.push_back(w);
                    else drop = 1'b1;
                    m_cnt  = 0;
                    m_word = '0;
                end else begin
                    m_cnt  = m_cnt + 1;
                    m_word = w;
                end
            end
            if (drop) m_ovr = 1'b1;
            else if (c) m_ovr = 1'b0;
        end
        @(posedge clk);
        #1;
        dat_valid_i = 1'b0; dat_last_i = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input bit pop_last, input bit clr_last);
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) tick(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(w[31 - 4 * k -: 4], 1'b1, 1'b0, pop_last && (k == 7), clr_last && (k == 7));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        vectors++;
        if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++;
        if (mem_fill !== 4'd0) begin miscompares++; $display("FAIL reset_fill: got %0d want 0", mem_fill); end
        vectors++;
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        vectors++;
    endtask

    task automatic test_pack_full_word();
        for (int k = 1; k <= 8; k++) begin
            tick(4'(k), 1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 7) begin
                if (empty !== 1'b1) begin miscompares++; $display("FAIL pack_early_empty: got %b want 1", empty); end
                vectors++;
            end
        end
        if (empty !== 1'b0) begin miscompares++; $display("FAIL pack_empty: got %b want 0", empty); end
        vectors++;
        if (q !== 32'h12345678) begin miscompares++; $display("FAIL pack_q: got %h want 12345678", q); end
        vectors++;
        if (mem_fill !== 4'd1) begin miscompares++; $display("FAIL pack_fill: got %0d want 1", mem_fill); end
        vectors++;
        tick(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (empty !== 1'b1) begin miscompares++; $display("FAIL pack_pop_empty: got %b want 1", empty); end
        vectors++;
        // Pop while empty must be ignored.
        tick(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (mem_fill !== 4'd0 || empty !== 1'b1) begin
            miscompares++; $display("FAIL empty_pop: fill %0d empty %b want 0 1", mem_fill, empty);
        end
        vectors++;
    endtask

    task automatic test_last_partial();
        logic [31:0] w;
        tick(4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4'hB, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
        if (q !== 32'hABC00000 || empty !== 1'b0) begin
            miscompares++; $display("FAIL last_q: got %h empty %b want abc00000 0", q, empty);
        end
        vectors++;
        tick(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        w = $urandom;
        push_word(w, 1'b0, 1'b0);
        if (q !== w || mem_fill !== 4'd1) begin
            miscompares++; $display("FAIL last_next_word: got %h fill %0d want %h 1", q, mem_fill, w);
        end
        vectors++;
        tick(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < DEPTH; i++) push_word($urandom, 1'b0, 1'b0);
        if (full !== 1'b1 || mem_fill !== 4'd8) begin
            miscompares++; $display("FAIL full_flags: full %b fill %0d want 1 8", full, mem_fill);
        end
        vectors++;
        push_word($urandom, 1'b0, 1'b0);
        if (overrun !== 1'b1 || overrun !== m_ovr) begin
            miscompares++; $display("FAIL ovr_set: got %b want 1", overrun);
        end
        vectors++;
        if (mem_fill !== 4'd8 || q !== m_head()) begin
            miscompares++; $display("FAIL ovr_contents: fill %0d q %h want 8 %h", mem_fill, q, m_head());
        end
        vectors++;
        tick(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        vectors++;
        // Drop and clear in the same cycle: the set wins.
        push_word($urandom, 1'b0, 1'b1);
        if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set_prio: got %b want 1", overrun); end
        vectors++;
        tick(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (overrun !== m_ovr) begin miscompares++; $display("FAIL ovr_clear2: got %b want %b", overrun, m_ovr); end
        vectors++;
    endtask

    task automatic test_full_with_pop();
        push_word($urandom, 1'b1, 1'b0);
        if (full !== 1'b1 || overrun !== 1'b0 || q !== m_head()) begin
            miscompares++;
            $display("FAIL full_pop: full %b ovr %b q %h want 1 0 %h", full, overrun, q, m_head());
        end
        vectors++;
        for (int i = 0; i < DEPTH; i++) begin
            if (q !== m_head() || empty !== 1'b0) begin
                miscompares++; $display("FAIL drain_%0d: got %h empty %b want %h 0", i, q, empty, m_head());
            end
            vectors++;
            tick(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        if (empty !== 1'b1 || mem_fill !== 4'd0) begin
            miscompares++; $display("FAIL drain_empty: empty %b fill %0d want 1 0", empty, mem_fill);
        end
        vectors++;
    endtask

    task automatic test_wrap_stream();
        int sent = 0;
        int iter = 0;
        logic v;
        while (sent < 160 && iter < 1000) begin
            v = ($urandom_range(0, 4) != 0);
            tick(4'($urandom), v, 1'b0, ($urandom_range(0, 1) == 1), 1'b0);
            if (v) sent++;
            iter++;
            if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                mem_fill !== 4'(mq.size()) || overrun !== m_ovr) begin
                miscompares++;
                $display("FAIL stream_flags: empty %b full %b fill %0d ovr %b want fill %0d ovr %b",
                         empty, full, mem_fill, overrun, mq.size(), m_ovr);
            end
            vectors++;
            if (mq.size() > 0 && q !== m_head()) begin
                miscompares++; $display("FAIL stream_q: got %h want %h", q, m_head());
            end
            vectors++;
        end
        if (sent < 160) begin miscompares++; $display("FAIL stream_budget: sent %0d want 160", sent); end
        vectors++;
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) begin
            if (q !== m_head()) begin miscompares++; $display("FAIL stream_drain: got %h want %h", q, m_head()); end
            vectors++;
            tick(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        if (empty !== 1'b1) begin miscompares++; $display("FAIL stream_end_empty: got %b want 1", empty); end
        vectors++;
    endtask

    task automatic test_reset_midword();
        push_word($urandom, 1'b0, 1'b0);
        push_word($urandom, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) tick(4'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        if (mem_fill !== 4'd2) begin miscompares++; $display("FAIL pre_rst_fill: got %0d want 2", mem_fill); end
        vectors++;
        rst = 1'b1;
        tick(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        if (empty !== 1'b1 || mem_fill !== 4'd0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst: empty %b fill %0d ovr %b want 1 0 0", empty, mem_fill, overrun);
        end
        vectors++;
        push_word(32'hFEDCBA98, 1'b0, 1'b0);
        if (q !== 32'hFEDCBA98 || mem_fill !== 4'd1) begin
            miscompares++; $display("FAIL midrst_word: got %h fill %0d want fedcba98 1", q, mem_fill);
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_pack_full_word();
        test_last_partial();
        test_full_overrun();
        test_full_with_pop();
        test_wrap_stream();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
